// File: rtl/jesd_rx_pkg.sv
// Shared types and defaults for the JESD204B receive path.
package jesd_rx_pkg;

  localparam int unsigned LMFC_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWaitLanes,
    StWaitRelease,
    StReleased,
    StError
  } eb_ctrl_state_e;

endpackage

// File: rtl/eb_release_ctrl_if.sv
// Control/status bundle between lane alignment logic and the elastic buffer release controller.
interface eb_release_ctrl_if
  import jesd_rx_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned BUFFER_SIZE = 128,
  parameter int unsigned LMFC_W      = LMFC_W_DEFAULT
);

  localparam int unsigned OCC_W = $clog2(BUFFER_SIZE);

  logic                 sync_en_i;
  logic [LMFC_W-1:0]    lmfc_period_i;
  logic [LMFC_W-1:0]    rbd_i;
  logic [NUM_LANES-1:0] lane_start_i;
  logic [NUM_LANES-1:0] eb_write_en_o;
  logic                 eb_release_no;
  logic                 lmfc_edge_o;
  logic                 released_o;
  logic                 err_o;
  logic [OCC_W-1:0]     occupancy_o;

  modport master (
    output sync_en_i, lmfc_period_i, rbd_i, lane_start_i,
    input  eb_write_en_o, eb_release_no, lmfc_edge_o, released_o, err_o, occupancy_o
  );

  modport slave (
    input  sync_en_i, lmfc_period_i, rbd_i, lane_start_i,
    output eb_write_en_o, eb_release_no, lmfc_edge_o, released_o, err_o, occupancy_o
  );

endinterface

// File: rtl/lmfc_counter.sv
// Free-running local multiframe clock counter; shared with the SYNC~ and SYSREF logic.
module lmfc_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] period_i,
  output logic [W-1:0] count_o,
  output logic         edge_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + W'(1);
    // Period 0 or 1 pins the count at 0; '>=' also recovers when the period shrinks.
    if (period_i <= W'(1) || count_q >= period_i - W'(1)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign edge_o  = (count_q == '0);

endmodule

// File: rtl/eb_release_ctrl.sv
// Enables per-lane elastic buffer writes at start-of-multiframe and releases all buffers
// together at a fixed offset within the LMFC for deterministic latency.
module eb_release_ctrl
  import jesd_rx_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned BUFFER_SIZE = 128,
  parameter int unsigned LMFC_W      = LMFC_W_DEFAULT
) (
  input logic              clk_i,
  input logic              rst_i,
  eb_release_ctrl_if.slave bus
);

  localparam int unsigned OCC_W = $clog2(BUFFER_SIZE);
  localparam logic [OCC_W-1:0] OccMax = OCC_W'(BUFFER_SIZE - 1);

  eb_ctrl_state_e       state_q, state_d;
  logic [NUM_LANES-1:0] seen_q, seen_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [NUM_LANES-1:0] write_en_q;
  logic                 release_n_q, released_q, err_q;
  logic [OCC_W-1:0]     occupancy_q;
  logic                 release_hit;

  logic [LMFC_W-1:0] lmfc_count, period_eff, rbd_eff;

  lmfc_counter #(
    .W(LMFC_W)
  ) u_lmfc (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .period_i(bus.lmfc_period_i),
    .count_o (lmfc_count),
    .edge_o  (bus.lmfc_edge_o)
  );

  always_comb begin
    period_eff = (bus.lmfc_period_i == '0) ? LMFC_W'(1) : bus.lmfc_period_i;
    rbd_eff    = (bus.rbd_i >= period_eff) ? period_eff - LMFC_W'(1) : bus.rbd_i;
  end

  always_comb begin
    state_d     = state_q;
    seen_d      = seen_q;
    occ_d       = occ_q;
    release_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        seen_d = '0;
        occ_d  = '0;
        if (bus.sync_en_i) state_d = StWaitLanes;
      end
      StWaitLanes: begin
        seen_d = seen_q | bus.lane_start_i;
        if (|seen_d && occ_q != OccMax) occ_d = occ_q + OCC_W'(1);
        if (occ_q == OccMax) begin
          state_d = StError;
          seen_d  = '0;
        end else if (&seen_d) begin
          state_d = StWaitRelease;
        end
      end
      StWaitRelease: begin
        if (occ_q != OccMax) occ_d = occ_q + OCC_W'(1);
        // Overflow wins over a coincident release slot.
        if (occ_q == OccMax) begin
          state_d = StError;
          seen_d  = '0;
        end else if (lmfc_count == rbd_eff) begin
          state_d     = StReleased;
          release_hit = 1'b1;
        end
      end
      StReleased: ;
      StError: seen_d = '0;
      default: state_d = StIdle;
    endcase
    if (state_q != StIdle && !bus.sync_en_i) begin
      state_d     = StIdle;
      seen_d      = '0;
      release_hit = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      seen_q      <= '0;
      occ_q       <= '0;
      write_en_q  <= '0;
      release_n_q <= 1'b1;
      released_q  <= 1'b0;
      err_q       <= 1'b0;
      occupancy_q <= '0;
    end else begin
      state_q     <= state_d;
      seen_q      <= seen_d;
      occ_q       <= occ_d;
      write_en_q  <= (state_d == StWaitLanes || state_d == StWaitRelease ||
                      state_d == StReleased) ? seen_d : '0;
      release_n_q <= (state_d != StReleased);
      released_q  <= (state_d == StReleased);
      err_q       <= (state_d == StError);
      if (release_hit) occupancy_q <= occ_q;
    end
  end

  assign bus.eb_write_en_o = write_en_q;
  assign bus.eb_release_no = release_n_q;
  assign bus.released_o    = released_q;
  assign bus.err_o         = err_q;
  assign bus.occupancy_o   = occupancy_q;

endmodule

// File: doc/eb_release_ctrl.md
# eb_release_ctrl

Release controller for the JESD204B receiver's per-lane elastic buffers. It tracks each lane's start-of-multiframe arrival and enables that lane's buffer writes at arrival. It releases all buffers together at a programmable offset (RBD) within the local multiframe clock (LMFC), which gives deterministic latency and lane-to-lane deskew. It sits between the lane alignment/ILAS logic and the `elastic_buffer` instances, driving their `ready_ni` and `release_ni` inputs.

## Interface
- `NUM_LANES`, 4, number of lanes/buffers controlled
- `BUFFER_SIZE`, 128, depth of each elastic buffer in words
- `LMFC_W`, 8, width of LMFC period and RBD fields
- `clk_i` in 1: device clock; one clock domain
- `rst_i` in 1: reset, asynchronous, active-high
- `sync_en_i` in 1: link sync enable; low forces IDLE
- `lmfc_period_i` in LMFC_W: LMFC period in clock cycles; 0 treated as 1
- `rbd_i` in LMFC_W: release offset within LMFC; values ≥ period are treated as period-1
- `lane_start_i` in NUM_LANES: per-lane start-of-multiframe detect, sampled and made sticky
- `eb_write_en_o` out NUM_LANES: drives the buffer's `ready_ni`; 1 means the buffer writes
- `eb_release_no` out 1: drives `release_ni` on all buffers; 0 means the buffers read
- `lmfc_edge_o` out 1: high while LMFC count == 0
- `released_o` out 1: high in RELEASED
- `err_o` out 1: high in ERROR (overflow)
- `occupancy_o` out $clog2(BUFFER_SIZE): cycles from first lane start to release, latched at release

## Operation
- LMFC counter:
  - Free-running from reset, counts 0..P-1 and wraps, where P = max(`lmfc_period_i`, 1).
  - Independent of FSM state.
- `seen_q[l]` is set by `lane_start_i[l]` in WAIT_LANES. It is cleared in IDLE and ERROR.
- `eb_write_en_o = seen_q` in WAIT_LANES, WAIT_RELEASE and RELEASED. It is 0 otherwise.
- Skew counter `occ_q`:
  - Cleared in IDLE.
  - Increments every cycle once any `seen_q` bit is set, until the FSM leaves WAIT_RELEASE.
  - Saturates at BUFFER_SIZE-1.
- FSM states and transitions:
  - IDLE: `eb_release_no`=1. Goes to WAIT_LANES when `sync_en_i`=1.
  - WAIT_LANES: goes to WAIT_RELEASE when all `seen_q` bits are set, including any bits set this cycle.
  - WAIT_RELEASE: goes to RELEASED on a cycle where LMFC count == effective RBD. The earliest release is the cycle after entry.
  - RELEASED: `eb_release_no`=0, `released_o`=1. `occupancy_o` holds the value latched on the transition.
  - ERROR: reached from WAIT_LANES or WAIT_RELEASE when `occ_q` reaches BUFFER_SIZE-1 before release. All `eb_write_en_o`=0, `eb_release_no`=1, `err_o`=1.
  - From any non-IDLE state, `sync_en_i`=0 goes to IDLE. The error condition takes priority over the release condition in the same cycle.
- Lane starts arriving after release are ignored. `seen_q` is already all-ones at that point.

## Timing
- All outputs are registered. `lmfc_edge_o` is decoded from the registered count.
- Reset values:
  - FSM in IDLE, LMFC count 0.
  - `eb_write_en_o`=0, `eb_release_no`=1, `released_o`=0, `err_o`=0, `occupancy_o`=0, `lmfc_edge_o`=1.
- Lane start latency: `lane_start_i[l]` sampled at edge N gives `eb_write_en_o[l]`=1 after edge N. The buffer's first write then occurs at edge N+1.
- Release latency: a match sampled at edge M gives `eb_release_no`=0 after edge M, and `occupancy_o` = M − N_first.
- `sync_en_i` low takes effect on the next edge.
- `rst_i` asserted mid-operation immediately forces all outputs and the LMFC count to their reset values.

## Structure
- Shared package `jesd_rx_pkg` holds:
  - the `eb_ctrl_state_e` enum (IDLE, WAIT_LANES, WAIT_RELEASE, RELEASED, ERROR);
  - the `LMFC_W` default.
- Sub-module `lmfc_counter`: period input, count output and edge output. It is reusable by the SYNC~ and SYSREF logic.

## Test plan
Common setup for all scenarios: `NUM_LANES`=4, `BUFFER_SIZE`=128, P=16, `rbd_i`=5. LMFC count 0 is at cycle 0 after reset release, and `sync_en_i`=1 from cycle 1.

1. Reset values: hold `rst_i` for 3 cycles → all outputs at their reset values. Assert `rst_i` mid-WAIT_RELEASE → immediate return to IDLE, `eb_write_en_o`=0.
2. Normal release: lane starts at cycles 10, 11, 12, 15 →
   - `eb_write_en_o` bits rise after those edges;
   - `eb_release_no`=0 after edge 21;
   - `occupancy_o`=11, `released_o`=1.
3. Overflow: lanes 0–2 start at cycle 10 and lane 3 never starts → ERROR after edge 137, `err_o`=1, all buffer controls safe. Drop `sync_en_i` → IDLE and `err_o`=0.
4. RBD clamp and edge cases:
   - `rbd_i`=20 with all lanes starting at cycle 10 → release at cycle 15, `occupancy_o`=5.
   - `lmfc_period_i`=0 → release on the cycle after all lanes are seen.
5. Re-sync: in RELEASED, drop `sync_en_i` for 1 cycle → IDLE with `eb_release_no`=1. Reassert and restart lanes at cycle 40 → release at cycle 53.
6. Simultaneous events: the last lane start coincides with LMFC count == RBD → no release that cycle; release on the next match, 16 cycles later.
